// File: rtl/as2650_bus_arbiter.sv
// Two-requester (CPU/DMA) bus arbiter for the AS2650 core: alternating grant,
// latched transaction, programmable wait-state strobe and one-cycle acknowledge.
module as2650_bus_arbiter #(
  parameter int ADR_W = 13,
  parameter int DW    = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cpu_opreq,
  input  logic             cpu_rw,
  input  logic             cpu_m_io,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [DW-1:0]    cpu_dout,
  output logic [DW-1:0]    cpu_din,
  output logic             cpu_opack,
  input  logic             dma_req,
  input  logic             dma_rw,
  input  logic             dma_m_io,
  input  logic [ADR_W-1:0] dma_adr,
  input  logic [DW-1:0]    dma_dout,
  output logic [DW-1:0]    dma_din,
  output logic             dma_ack,
  input  logic [2:0]       wait_cfg,
  output logic [ADR_W-1:0] bus_adr,
  output logic [DW-1:0]    bus_dout,
  input  logic [DW-1:0]    bus_din,
  output logic             bus_oeb,
  output logic             bus_mreq,
  output logic             bus_ioreq,
  output logic             bus_we
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADDR   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state_r;
  logic       last_dma_r;
  logic       owner_dma_r;
  logic       mask_r;
  logic       m_io_r;
  logic [2:0] wait_r;
  logic [2:0] cnt_r;

  logic       cpu_ok_s;
  logic       dma_ok_s;
  logic       pick_dma_s;

  // Request qualification and alternating winner selection
  always_comb begin
    // mask_r is only set for the first IDLE cycle; last_dma_r then names the requester just acknowledged
    cpu_ok_s = cpu_opreq & ~(mask_r & ~last_dma_r);
    dma_ok_s = dma_req & ~(mask_r & last_dma_r);
    if (cpu_ok_s && dma_ok_s) begin
      pick_dma_s = ~last_dma_r;
    end else if (dma_ok_s) begin
      pick_dma_s = 1'b1;
    end else begin
      pick_dma_s = 1'b0;
    end
  end

  // Transaction sequencer with registered bus and handshake outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r     <= IDLE;
      last_dma_r  <= 1'b0;
      owner_dma_r <= 1'b0;
      mask_r      <= 1'b0;
      m_io_r      <= 1'b0;
      wait_r      <= 3'd0;
      cnt_r       <= 3'd0;
      bus_adr     <= {ADR_W{1'b0}};
      bus_dout    <= {DW{1'b0}};
      cpu_din     <= {DW{1'b0}};
      dma_din     <= {DW{1'b0}};
      bus_oeb     <= 1'b1;
      bus_mreq    <= 1'b0;
      bus_ioreq   <= 1'b0;
      bus_we      <= 1'b0;
      cpu_opack   <= 1'b0;
      dma_ack     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mask_r <= 1'b0;
          if (cpu_ok_s || dma_ok_s) begin
            state_r     <= ADDR;
            last_dma_r  <= pick_dma_s;
            owner_dma_r <= pick_dma_s;
            wait_r      <= wait_cfg;
            if (pick_dma_s) begin
              bus_adr  <= dma_adr;
              bus_dout <= dma_dout;
              bus_we   <= dma_rw;
              bus_oeb  <= ~dma_rw;
              m_io_r   <= dma_m_io;
            end else begin
              bus_adr  <= cpu_adr;
              bus_dout <= cpu_dout;
              bus_we   <= cpu_rw;
              bus_oeb  <= ~cpu_rw;
              m_io_r   <= cpu_m_io;
            end
          end
        end
        ADDR: begin
          state_r   <= ACCESS;
          cnt_r     <= 3'd0;
          bus_mreq  <= m_io_r;
          bus_ioreq <= ~m_io_r;
        end
        ACCESS: begin
          if (cnt_r == wait_r) begin
            state_r   <= DONE;
            bus_mreq  <= 1'b0;
            bus_ioreq <= 1'b0;
            if (owner_dma_r) begin
              dma_ack <= 1'b1;
              if (!bus_we) begin
                dma_din <= bus_din;
              end
            end else begin
              cpu_opack <= 1'b1;
              if (!bus_we) begin
                cpu_din <= bus_din;
              end
            end
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          cpu_opack <= 1'b0;
          dma_ack   <= 1'b0;
          bus_oeb   <= 1'b1;
          bus_we    <= 1'b0;
          mask_r    <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_as2650_bus_arbiter.sv
// Scoreboard bench for as2650_bus_arbiter: expected transactions are queued on
// request and popped/compared when the matching acknowledge appears.
module tb_as2650_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_opreq, cpu_rw, cpu_m_io;
  logic [12:0] cpu_adr;
  logic [7:0]  cpu_dout, cpu_din;
  logic        cpu_opack;
  logic        dma_req, dma_rw, dma_m_io;
  logic [12:0] dma_adr;
  logic [7:0]  dma_dout, dma_din;
  logic        dma_ack;
  logic [2:0]  wait_cfg;
  logic [12:0] bus_adr;
  logic [7:0]  bus_dout, bus_din;
  logic        bus_oeb, bus_mreq, bus_ioreq, bus_we;

  int passed = 0;
  int total  = 0;

  typedef struct {
    bit          is_dma;
    bit          rw;
    bit          m_io;
    logic [12:0] adr;
    logic [7:0]  dout;
    logic [7:0]  rdata;
    int          w;
  } txn_t;

  txn_t exp_q[$];
  bit   ord_q[$];

  as2650_bus_arbiter #(.ADR_W(13), .DW(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cpu_opreq(cpu_opreq),
    .cpu_rw   (cpu_rw),
    .cpu_m_io (cpu_m_io),
    .cpu_adr  (cpu_adr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_opack(cpu_opack),
    .dma_req  (dma_req),
    .dma_rw   (dma_rw),
    .dma_m_io (dma_m_io),
    .dma_adr  (dma_adr),
    .dma_dout (dma_dout),
    .dma_din  (dma_din),
    .dma_ack  (dma_ack),
    .wait_cfg (wait_cfg),
    .bus_adr  (bus_adr),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .bus_oeb  (bus_oeb),
    .bus_mreq (bus_mreq),
    .bus_ioreq(bus_ioreq),
    .bus_we   (bus_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input bit is_dma, input bit v);
    if (is_dma) dma_req = v;
    else cpu_opreq = v;
  endtask

  // One complete transaction: drive, measure strobe/oeb/latency, pop and compare
  task automatic do_txn(input string name, input bit is_dma, input bit rw, input bit m_io,
                        input logic [12:0] adr, input logic [7:0] dout, input int w,
                        input logic [7:0] rd, input bit hold_extra, input bit bump_wait,
                        input bit drop_mid);
    txn_t t;
    int lat, strobe, wrong, oeb_lo, bad, other, extra;
    bit got;
    logic [7:0] din_v;
    repeat (2) @(negedge clk);
    bus_din  = rd;
    wait_cfg = 3'(w);
    if (is_dma) begin
      dma_rw = rw; dma_m_io = m_io; dma_adr = adr; dma_dout = dout;
    end else begin
      cpu_rw = rw; cpu_m_io = m_io; cpu_adr = adr; cpu_dout = dout;
    end
    set_req(is_dma, 1'b1);
    t.is_dma = is_dma; t.rw = rw; t.m_io = m_io; t.adr = adr;
    t.dout = dout; t.rdata = rd; t.w = w;
    exp_q.push_back(t);
    lat = 0; strobe = 0; wrong = 0; oeb_lo = 0; bad = 0; other = 0; got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (bus_mreq || bus_ioreq) begin
        if ((m_io && bus_mreq) || (!m_io && bus_ioreq)) strobe++;
        if ((m_io && bus_ioreq) || (!m_io && bus_mreq)) wrong++;
        if (bus_adr !== adr || bus_we !== rw || (rw && bus_dout !== dout)) bad++;
        if (bump_wait) wait_cfg = 3'd7;
      end
      if (!bus_oeb) oeb_lo++;
      if (is_dma ? cpu_opack : dma_ack) other++;
      if (is_dma ? dma_ack : cpu_opack) begin
        got = 1'b1;
        lat = n;
      end
      // inputs changing after the grant must not disturb the transaction
      if (n == 1) begin
        if (is_dma) begin
          dma_adr = ~adr; dma_dout = ~dout; dma_rw = ~rw; dma_m_io = ~m_io;
        end else begin
          cpu_adr = ~adr; cpu_dout = ~dout; cpu_rw = ~rw; cpu_m_io = ~m_io;
        end
      end
      if (n == 2 && drop_mid) set_req(is_dma, 1'b0);
    end
    if (!hold_extra) set_req(is_dma, 1'b0);
    total++;
    if (!got) $display("FAIL %s ack_timeout: got no ack want ack within 40 cycles", name);
    else passed++;
    t = exp_q.pop_front();
    total++;
    if (lat !== t.w + 3) $display("FAIL %s latency: got %0d want %0d", name, lat, t.w + 3);
    else passed++;
    total++;
    if (strobe !== t.w + 1) $display("FAIL %s strobe_width: got %0d want %0d", name, strobe, t.w + 1);
    else passed++;
    total++;
    if (wrong !== 0) $display("FAIL %s wrong_strobe: got %0d want 0", name, wrong);
    else passed++;
    total++;
    if (bad !== 0) $display("FAIL %s bus_fields: got %0d bad cycles want 0", name, bad);
    else passed++;
    total++;
    if (oeb_lo !== (t.rw ? t.w + 3 : 0))
      $display("FAIL %s oeb_low_cycles: got %0d want %0d", name, oeb_lo, t.rw ? t.w + 3 : 0);
    else passed++;
    total++;
    if (other !== 0) $display("FAIL %s other_ack: got %0d want 0", name, other);
    else passed++;
    if (!t.rw) begin
      din_v = t.is_dma ? dma_din : cpu_din;
      total++;
      if (din_v !== t.rdata) $display("FAIL %s read_data: got %h want %h", name, din_v, t.rdata);
      else passed++;
    end
    @(negedge clk);
    total++;
    if ((is_dma ? dma_ack : cpu_opack) !== 1'b0) $display("FAIL %s ack_width: got ack still high want low", name);
    else passed++;
    if (hold_extra) begin
      @(negedge clk);
      set_req(is_dma, 1'b0);
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus_mreq || bus_ioreq || cpu_opack || dma_ack) extra++;
      end
      total++;
      if (extra !== 0) $display("FAIL %s retrigger: got %0d active cycles want 0", name, extra);
      else passed++;
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus_adr, bus_dout, cpu_din, dma_din, bus_oeb, bus_mreq, bus_ioreq, bus_we, cpu_opack, dma_ack}
        !== {13'h0, 8'h0, 8'h0, 8'h0, 1'b1, 5'b0})
      $display("FAIL reset_values: got adr=%h dout=%h cdin=%h ddin=%h oeb=%b mreq=%b ioreq=%b we=%b cack=%b dack=%b",
               bus_adr, bus_dout, cpu_din, dma_din, bus_oeb, bus_mreq, bus_ioreq, bus_we, cpu_opack, dma_ack);
    else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cpu_mem_read;
    do_txn("cpu_mem_read", 1'b0, 1'b0, 1'b1, 13'h0123, 8'h00, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_dma_io_write;
    do_txn("dma_io_write", 1'b1, 1'b1, 1'b0, 13'h1FFF, 8'h3C, 3, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wait_change;
    do_txn("wait_change", 1'b0, 1'b0, 1'b1, 13'h0456, 8'h00, 2, 8'h5A, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_drop_mid;
    do_txn("drop_mid", 1'b1, 1'b0, 1'b0, 13'h0A0A, 8'h00, 1, 8'hC3, 1'b0, 1'b0, 1'b1);
    total++;
    if (cpu_din !== 8'h5A) $display("FAIL cpu_din_hold: got %h want 5a", cpu_din);
    else passed++;
  endtask

  task automatic test_max_wait;
    do_txn("max_wait", 1'b0, 1'b0, 1'b0, 13'h1555, 8'h00, 7, 8'h7E, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_past_ack;
    do_txn("hold_past_ack", 1'b0, 1'b1, 1'b1, 13'h0042, 8'h99, 0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int acks = 0;
    int both = 0;
    bit e;
    @(negedge clk);
    rst = 1'b1;
    cpu_rw = 1'b0; cpu_m_io = 1'b1; cpu_adr = 13'h0100;
    dma_rw = 1'b0; dma_m_io = 1'b1; dma_adr = 13'h0200;
    wait_cfg = 3'd0; bus_din = 8'h11;
    cpu_opreq = 1'b1; dma_req = 1'b1;
    ord_q.push_back(1'b1); ord_q.push_back(1'b0);
    ord_q.push_back(1'b1); ord_q.push_back(1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 100 && acks < 4; n++) begin
      @(negedge clk);
      if (cpu_opack && dma_ack) begin
        both++;
      end else if (cpu_opack || dma_ack) begin
        e = ord_q.pop_front();
        total++;
        if (dma_ack !== e) $display("FAIL grant_order_%0d: got dma=%b want dma=%b", acks, dma_ack, e);
        else passed++;
        acks++;
      end
    end
    cpu_opreq = 1'b0; dma_req = 1'b0;
    total++;
    if (acks !== 4) $display("FAIL b2b_ack_count: got %0d want 4", acks);
    else passed++;
    total++;
    if (both !== 0) $display("FAIL b2b_dual_ack: got %0d want 0", both);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int found = 0;
    int extra = 0;
    repeat (2) @(negedge clk);
    cpu_rw = 1'b1; cpu_m_io = 1'b1; cpu_adr = 13'h0AAA; cpu_dout = 8'h55;
    wait_cfg = 3'd2;
    cpu_opreq = 1'b1;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clk);
      if (bus_mreq) found = 1;
    end
    total++;
    if (found == 0) $display("FAIL rmid_strobe_timeout: got no strobe want strobe within 20 cycles");
    else passed++;
    @(negedge clk);
    total++;
    if ({bus_mreq, bus_oeb} !== 2'b10) $display("FAIL rmid_pre_reset: got mreq=%b oeb=%b want 1 0", bus_mreq, bus_oeb);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({bus_adr, bus_oeb, bus_mreq, bus_ioreq, bus_we, cpu_opack, dma_ack} !== {13'h0, 1'b1, 5'b0})
      $display("FAIL rmid_reset_values: got adr=%h oeb=%b mreq=%b ioreq=%b we=%b cack=%b dack=%b",
               bus_adr, bus_oeb, bus_mreq, bus_ioreq, bus_we, cpu_opack, dma_ack);
    else passed++;
    cpu_opreq = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_opack || dma_ack || bus_mreq || bus_ioreq) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL rmid_no_ack: got %0d active cycles want 0", extra);
    else passed++;
    do_txn("post_reset_read", 1'b0, 1'b0, 1'b1, 13'h0040, 8'h00, 1, 8'h96, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    cpu_opreq = 1'b0; cpu_rw = 1'b0; cpu_m_io = 1'b0; cpu_adr = 13'h0; cpu_dout = 8'h0;
    dma_req = 1'b0; dma_rw = 1'b0; dma_m_io = 1'b0; dma_adr = 13'h0; dma_dout = 8'h0;
    wait_cfg = 3'd0; bus_din = 8'h0;
    test_reset();
    test_cpu_mem_read();
    test_dma_io_write();
    test_wait_change();
    test_drop_mid();
    test_max_wait();
    test_hold_past_ack();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/as2650_bus_arbiter.md
AS2650_BUS_ARBITER -- requirements
Module: as2650_bus_arbiter

Interface
REQ-001 Parameter: ADR_W, 13, address width of both requesters and the bus.
REQ-002 Parameter: DW, 8, data width.
REQ-003 wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 wb_rst_i  input  1  reset; asynchronous, active-high.
REQ-005 cpu_opreq  input  1  CPU operation request; held until cpu_opack.
REQ-006 cpu_rw  input  1  CPU direction; 1 = write, 0 = read.
REQ-007 cpu_m_io  input  1  CPU space; 1 = memory, 0 = I/O.
REQ-008 cpu_adr  input  ADR_W  CPU address.
REQ-009 cpu_dout  input  DW  CPU write data.
REQ-010 cpu_din  output  DW  CPU read data register.
REQ-011 cpu_opack  output  1  one-cycle CPU completion pulse.
REQ-012 dma_req, dma_rw, dma_m_io, dma_adr, dma_dout  inputs  1,1,1,ADR_W,DW  DMA requester; same meanings as the CPU inputs.
REQ-013 dma_din  output  DW  DMA read data register; dma_ack  output  1  one-cycle DMA completion pulse.
REQ-014 wait_cfg  input  3  wait states per access, 0..7.
REQ-015 bus_adr  output  ADR_W  bus address; bus_dout  output  DW  bus write data; bus_din  input  DW  bus read data.
REQ-016 bus_oeb  output  1  data-pad output enable, active-low.
REQ-017 bus_mreq, bus_ioreq, bus_we  outputs  1 each  memory strobe, I/O strobe, write qualifier.

Function
REQ-018 FSM states: IDLE, ADDR, ACCESS, DONE; IDLE->ADDR on grant; ADDR->ACCESS always; ACCESS->DONE when wait counter equals latched wait; DONE->IDLE always.
REQ-019 Arbitration in IDLE only; single requester wins; on simultaneous requests the requester not granted last wins; last-grant register resets to CPU.
REQ-020 On grant, latch the winner's rw, m_io, adr, dout and wait_cfg; later input changes do not affect the transaction.
REQ-021 ADDR: bus_adr/bus_dout/bus_we driven from the latch; strobes low.
REQ-022 ACCESS: bus_mreq (m_io=1) or bus_ioreq (m_io=0) high for exactly latched wait_cfg+1 cycles; the other strobe stays low.
REQ-023 Read: bus_din captured into the winner's din register on the last ACCESS edge; it holds until that requester's next read completes.
REQ-024 bus_oeb low in ADDR, ACCESS and DONE of a write; high otherwise.
REQ-025 DONE: strobes low; winner's ack high for exactly this cycle; the other ack stays low.
REQ-026 Latency: grant edge to ack = wait_cfg+3 cycles; back-to-back transactions are separated by at least one IDLE cycle.
REQ-027 First IDLE cycle after DONE masks the just-acknowledged requester, so a request held one cycle past ack does not re-trigger.
REQ-028 Requester dropping its request mid-transaction: the transaction completes and ack still pulses.
REQ-029 Wait counter is 3 bits, counts from 0 in ACCESS, and never wraps.

Reset
REQ-030 While wb_rst_i is high, all of the following hold at once without a clock: state IDLE; bus_adr, bus_dout, cpu_din, dma_din = 0; bus_oeb = 1; bus_mreq, bus_ioreq, bus_we, cpu_opack, dma_ack = 0; last grant = CPU.
REQ-031 Reset mid-transaction aborts it with no ack; after release, arbitration restarts in IDLE.

Verification
REQ-032 CPU memory read, wait_cfg=0, cpu_adr=0x0123, bus_din=0xA5 -> bus_mreq high 1 cycle, cpu_opack 3 cycles after grant, cpu_din=0xA5.
REQ-033 DMA I/O write, wait_cfg=3, dma_adr=0x1FFF, dma_dout=0x3C -> bus_ioreq high 4 cycles, bus_we=1, bus_oeb low from ADDR through DONE, dma_ack 6 cycles after grant.
REQ-034 Both requests held continuously from reset release -> grants DMA, CPU, DMA, CPU; each ack pulses once per grant.
REQ-035 wait_cfg changed 2->7 during ACCESS -> strobe width stays 3 cycles.
REQ-036 wb_rst_i asserted in the 2nd ACCESS cycle -> strobes and bus_oeb return to reset values immediately, no ack; a fresh CPU read completes normally after release.
REQ-037 cpu_opreq held one cycle past cpu_opack -> no second transaction starts.
